// File: rtl/dds_multi.sv
// Time-multiplexed multi-channel DDS: per-channel phase accumulators feeding one shared
// quarter-wave sine ROM through an issue -> ROM -> shadow pipeline, committed all at once.
module dds_multi #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int N_CH    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH*PHASE_W-1:0] K,
    input  logic [N_CH*PHASE_W-1:0] offset,
    input  logic [2*N_CH-1:0]       mode,
    input  logic                    sync,
    input  logic                    sampling_pulse,
    output logic [N_CH*DATA_W-1:0]  sample,
    output logic                    new_sample_ready,
    output logic                    busy,
    output logic                    overrun
);
    localparam int CNT_W = $clog2(N_CH + 2);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ROM_D = 2 ** ADDR_W;
    localparam real PI   = 3.141592653589793;

    localparam logic signed [DATA_W-1:0] AMP      = DATA_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic [DATA_W-1:0]        MSB_MASK = {1'b1, {(DATA_W - 1){1'b0}}};

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SAW    = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMMIT} state_e;

    // Quarter-wave table: entry i = round(AMP * sin(pi/2 * i / 2^ADDR_W)), built at elaboration.
    logic [DATA_W-1:0] rom_tbl [ROM_D];
    for (genvar g = 0; g < ROM_D; g++) begin : g_rom
        localparam int VAL = $rtoi(real'(2 ** (DATA_W - 1) - 1)
                                   * $sin(PI / 2.0 * real'(g) / real'(ROM_D)) + 0.5);
        assign rom_tbl[g] = DATA_W'(VAL);
    end

    function automatic logic [ADDR_W-1:0] sine_addr(input logic [PHASE_W-1:0] p);
        logic [ADDR_W-1:0] i;
        i = p[PHASE_W-3 -: ADDR_W];
        if (!p[PHASE_W-2])
            return i;
        else if (i == '0)
            return '1;  // exact quarter point: clamp to the last entry instead of wrapping to 0
        else
            return ~i + 1'b1;
    endfunction

    function automatic logic signed [DATA_W-1:0] sine_val(input logic [DATA_W-1:0] r,
                                                          input logic neg);
        return neg ? -$signed(r) : $signed(r);
    endfunction

    function automatic logic signed [DATA_W-1:0] wave_val(input logic [PHASE_W-1:0] p,
                                                          input logic [1:0] md);
        logic [DATA_W-1:0]        b;
        logic signed [DATA_W-1:0] v;
        b = p[PHASE_W-2 -: DATA_W];
        case (md)
            MODE_SQUARE: v = p[PHASE_W-1] ? -AMP : AMP;
            MODE_TRI:    v = $signed((p[PHASE_W-1] ? ~b : b) ^ MSB_MASK);
            MODE_SAW:    v = $signed(p[PHASE_W-1 -: DATA_W] ^ MSB_MASK);
            default:     v = '0;
        endcase
        return v;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;
    logic             overrun_q, overrun_d;
    logic             ready_q;
    logic             accept, issue, commit;
    logic [CH_W-1:0]  ch_sel;

    logic [PHASE_W-1:0] k_a   [N_CH];
    logic [PHASE_W-1:0] off_a [N_CH];
    logic [1:0]         mode_a [N_CH];
    logic [PHASE_W-1:0] acc_q [N_CH];
    logic signed [DATA_W-1:0] shadow_q [N_CH];
    logic signed [DATA_W-1:0] sample_q [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_pack
        assign k_a[c]    = K[c*PHASE_W +: PHASE_W];
        assign off_a[c]  = offset[c*PHASE_W +: PHASE_W];
        assign mode_a[c] = mode[2*c +: 2];
        assign sample[c*DATA_W +: DATA_W] = sample_q[c];
    end

    assign ch_sel           = cnt_q[CH_W-1:0];
    assign busy             = (state_q != S_IDLE);
    assign overrun          = overrun_q;
    assign new_sample_ready = ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sync_d    = sync_q;
        overrun_d = overrun_q;
        accept    = 1'b0;
        issue     = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept = sampling_pulse;
            end
            S_RUN: begin
                // First N_CH cycles issue channels; the last two drain ROM and shadow stages.
                issue = (cnt_q < CNT_W'(N_CH));
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_CH + 1))
                    state_d = S_COMMIT;
                if (sampling_pulse)
                    overrun_d = 1'b1;
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
                accept  = sampling_pulse;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_RUN;
            cnt_d   = '0;
            sync_d  = sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sync_q    <= 1'b0;
            overrun_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            overrun_q <= overrun_d;
            ready_q   <= commit;
        end
    end

    logic [PHASE_W-1:0]       acc_nx;
    logic [PHASE_W-1:0]       ph_p1_q;
    logic [1:0]               mode_p1_q, mode_p2_q;
    logic [CH_W-1:0]          ch_p1_q, ch_p2_q;
    logic                     vld_p1_q, vld_p2_q;
    logic [DATA_W-1:0]        rom_p2_q;
    logic                     neg_p2_q;
    logic signed [DATA_W-1:0] wave_p2_q;

    assign acc_nx = (sync_q ? '0 : acc_q[ch_sel]) + k_a[ch_sel];

    // p1: issue (phase), p2: ROM read with mode/quadrant carried along, p3: shadow write
    always_ff @(posedge clk) begin
        if (issue) begin
            ph_p1_q   <= acc_nx + off_a[ch_sel];
            mode_p1_q <= mode_a[ch_sel];
            ch_p1_q   <= ch_sel;
        end
        rom_p2_q  <= rom_tbl[sine_addr(ph_p1_q)];
        neg_p2_q  <= ph_p1_q[PHASE_W-1];
        wave_p2_q <= wave_val(ph_p1_q, mode_p1_q);
        mode_p2_q <= mode_p1_q;
        ch_p2_q   <= ch_p1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c]    <= '0;
                shadow_q[c] <= '0;
                sample_q[c] <= '0;
            end
        end else begin
            vld_p1_q <= issue;
            vld_p2_q <= vld_p1_q;
            if (issue)
                acc_q[ch_sel] <= acc_nx;
            if (vld_p2_q)
                shadow_q[ch_p2_q] <= (mode_p2_q == MODE_SINE) ? sine_val(rom_p2_q, neg_p2_q)
                                                                : wave_p2_q;
            if (commit)
                for (int c = 0; c < N_CH; c++)
                    sample_q[c] <= shadow_q[c];
        end
    end

endmodule

// File: tb/tb_dds_multi.sv
// Bench for dds_multi: transaction-level model (one sample set computed per accepted pulse)
// compared every cycle, plus directed literal checks of the key waveform values and timing.
module tb_dds_multi;
    localparam int PW   = 24;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int NCH  = 2;
    localparam int LAT  = NCH + 3;
    localparam int AMPL = 2 ** (DW - 1) - 1;

    localparam logic [PW-1:0] K20 = 24'h10_0000;
    localparam logic [PW-1:0] K22 = 24'h40_0000;
    localparam logic [PW-1:0] K23 = 24'h80_0000;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic [NCH*PW-1:0] K      = '0;
    logic [NCH*PW-1:0] offset = '0;
    logic [2*NCH-1:0]  mode   = '0;
    logic              sync   = 1'b0;
    logic              pulse  = 1'b0;
    logic [NCH*DW-1:0] sample;
    logic              ready, busy, overrun;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    int exp_sine [4] = '{32767, 0, -32767, 0};
    int exp_sq   [4] = '{-32767, 32767, -32767, 32767};

    always #5 clk = ~clk;

    dds_multi #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW), .N_CH(NCH)) dut (
        .clk              (clk),
        .reset            (reset),
        .K                (K),
        .offset           (offset),
        .mode             (mode),
        .sync             (sync),
        .sampling_pulse   (pulse),
        .sample           (sample),
        .new_sample_ready (ready),
        .busy             (busy),
        .overrun          (overrun)
    );

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic logic signed [31:0] sval(input int c);
        return 32'($signed(sample[c*DW +: DW]));
    endfunction

    // ---------------- behavioural model ----------------
    longint edge_n  = 0;
    longint run_end = -100;
    logic [PW-1:0] m_acc [NCH];
    int  m_pend [NCH];
    int  m_samp [NCH];
    logic m_ready = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;

    function automatic int rom_model(input int a);
        return $rtoi(real'(AMPL) * $sin(3.141592653589793 / 2.0 * real'(a) / real'(2 ** AW)) + 0.5);
    endfunction

    function automatic int wave(input logic [PW-1:0] p, input logic [1:0] md);
        int q, i, a, b, v;
        q = int'(p >> (PW - 2));
        i = int'(p >> (PW - 2 - AW)) % (2 ** AW);
        case (md)
            2'd0: begin
                if (q % 2 == 0) a = i;
                else if (i == 0) a = 2 ** AW - 1;
                else a = 2 ** AW - i;
                v = (q >= 2) ? -rom_model(a) : rom_model(a);
            end
            2'd1: v = (q >= 2) ? -AMPL : AMPL;
            2'd2: begin
                b = int'(p >> (PW - 1 - DW)) % (2 ** DW);
                if (q >= 2) b = 2 ** DW - 1 - b;
                v = b - 2 ** (DW - 1);
            end
            default: v = int'(p >> (PW - DW)) - 2 ** (DW - 1);
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c]  = '0;
                m_samp[c] = 0;
            end
            m_ready = 1'b0;
            m_ovr   = 1'b0;
            m_busy  = 1'b0;
            run_end = -100;
        end else begin
            edge_n++;
            m_ready = 1'b0;
            if (edge_n == run_end) begin
                for (int c = 0; c < NCH; c++) m_samp[c] = m_pend[c];
                m_ready = 1'b1;
            end
            if (pulse) begin
                if (edge_n >= run_end) begin
                    for (int c = 0; c < NCH; c++) begin
                        m_acc[c]  = (sync ? '0 : m_acc[c]) + K[c*PW +: PW];
                        m_pend[c] = wave(m_acc[c] + offset[c*PW +: PW], mode[2*c +: 2]);
                    end
                    run_end = edge_n + LAT;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            m_busy = (edge_n < run_end);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", 32'(ready), 32'(m_ready));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            for (int c = 0; c < NCH; c++)
                chk($sformatf("sample[%0d]", c), sval(c), m_samp[c]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fire(input bit s);
        pulse = 1'b1;
        sync  = s;
        tick(1);
        pulse = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic await_ready(output int lat);
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (ready !== 1'b1 && lat < 20);
    endtask

    task automatic count_ready(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick(1);
            if (ready === 1'b1) cnt++;
        end
    endtask

    task automatic set_ch(input int c, input logic [PW-1:0] k, input logic [PW-1:0] off,
                          input logic [1:0] md);
        K[c*PW +: PW]      = k;
        offset[c*PW +: PW] = off;
        mode[2*c +: 2]     = md;
    endtask

    initial begin
        int lat, cnt;
        tick(2);
        cmp_en = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_sample0", sval(0), 0);
        reset = 1'b1;
        tick(2);

        // sine on ch0 (quarter-turn steps), square on ch1 (half-turn steps)
        set_ch(0, K22, '0, 2'd0);
        set_ch(1, K23, '0, 2'd1);
        for (int n = 0; n < 4; n++) begin
            fire(1'b0);
            await_ready(lat);
            chk($sformatf("lat_sine%0d", n), lat, 5);
            chk($sformatf("sine%0d", n), sval(0), exp_sine[n]);
            chk($sformatf("square%0d", n), sval(1), exp_sq[n]);
            tick(2);
        end

        // half-turn offset moves ch0 into the opposite-sign quadrant
        set_ch(0, K22, K23, 2'd0);
        fire(1'b0);
        await_ready(lat);
        chk("sine_offset", sval(0), -32767);
        tick(2);

        // pulse in the commit cycle is accepted back to back
        fire(1'b0);
        tick(4);
        fire(1'b0);
        chk("cc_busy", 32'(busy), 1);
        chk("cc_ready_first", 32'(ready), 1);
        await_ready(lat);
        chk("lat_commit_pulse", lat, 5);
        chk("cc_no_overrun", 32'(overrun), 0);
        tick(2);

        // reset mid-run discards the set and clears accumulators
        fire(1'b0);
        tick(2);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_sample0", sval(0), 0);
        chk("midrst_sample1", sval(1), 0);
        tick(1);
        reset = 1'b1;
        count_ready(10, cnt);
        chk("midrst_no_ready", cnt, 0);

        // sawtooth / triangle from acc = 0, then swap modes
        set_ch(0, K20, '0, 2'd3);
        set_ch(1, K20, '0, 2'd2);
        fire(1'b0);
        await_ready(lat);
        chk("saw_first", sval(0), -28672);
        chk("tri_first", sval(1), -24576);
        tick(2);
        set_ch(0, K20, '0, 2'd2);
        set_ch(1, K20, '0, 2'd3);
        fire(1'b0);
        await_ready(lat);
        chk("tri_swapped", sval(0), -16384);
        chk("saw_swapped", sval(1), -24576);
        tick(2);

        // second pulse two cycles in: ignored, sticky overrun, one ready only
        fire(1'b0);
        tick(1);
        fire(1'b0);
        count_ready(12, cnt);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_ready_count", cnt, 1);

        // sync restarts both accumulators at K
        set_ch(0, K22, '0, 2'd0);
        set_ch(1, K23, '0, 2'd1);
        fire(1'b1);
        await_ready(lat);
        chk("sync_sine", sval(0), 32767);
        chk("sync_square", sval(1), -32767);
        tick(2);

        // random traffic; configuration only changes alongside a pulse that will be accepted
        for (int n = 0; n < 300; n++) begin
            tick($urandom_range(0, 6));
            if (edge_n + 1 >= run_end) begin
                for (int c = 0; c < NCH; c++)
                    set_ch(c, PW'($urandom), PW'($urandom), 2'($urandom_range(0, 3)));
                fire($urandom_range(0, 7) == 0);
            end else begin
                fire(1'b0);
            end
        end
        tick(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dds_multi.md
# dds_multi

Time-multiplexed, multi-channel direct digital synthesiser. It is the parametrised successor of the single-channel sine DDS. Each of N_CH channels has its own phase accumulator, tuning word, phase offset and waveform mode (sine, square, triangle, sawtooth). All channels share one quarter-wave sine ROM (synchronous read, 1-cycle latency) through a pipelined sequencer that starts on each sampling pulse. The block sits between the sample-rate timer and the DAC/audio path.

## Interface
- PHASE_W, 24, accumulator/tuning-word width; must be ≥ max(ADDR_W+2, DATA_W+1)
- ADDR_W, 10, quarter-wave ROM address width (depth 2^ADDR_W)
- DATA_W, 16, signed sample width
- N_CH, 2, channel count (≥1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- K  in  N_CH*PHASE_W  packed tuning words, channel c at [c*PHASE_W +: PHASE_W]
- offset  in  N_CH*PHASE_W  packed phase offsets, same packing
- mode  in  2*N_CH  per channel: 0 sine, 1 square, 2 triangle, 3 sawtooth
- sync  in  1  phase clear, qualified by an accepted sampling_pulse
- sampling_pulse  in  1  single-cycle request for a new sample set
- sample  out  N_CH*DATA_W  packed signed samples, channel c at [c*DATA_W +: DATA_W]
- new_sample_ready  out  1  one-cycle pulse: sample just updated
- busy  out  1  sequencer active
- overrun  out  1  sticky: a pulse arrived while busy

## Operation
- States IDLE → RUN → COMMIT → IDLE. A pulse is accepted when it is sampled in IDLE, or in the COMMIT cycle.
- RUN issues channels 0..N_CH-1 on consecutive cycles. The issue stage for channel c does the following:
  - acc[c] <= acc[c] + K[c]. If sync was high with the accepting pulse: acc[c] <= K[c].
  - The phase register p <= new acc + offset[c], mod 2^PHASE_W.
  - K, offset and mode are sampled at the channel's own issue edge.
- Sine decode:
  - q = p[PHASE_W-1:PHASE_W-2]; i = p[PHASE_W-3 -: ADDR_W].
  - Even q: addr = i. Odd q: addr = 2^ADDR_W − i, except i=0, which gives addr = 2^ADDR_W−1 (clamp).
  - q ≥ 2: output = −ROM. ROM holds non-negative values ≤ 2^(DATA_W-1)−1.
- Square: p MSB 0 → +(2^(DATA_W-1)−1); MSB 1 → −(2^(DATA_W-1)−1).
- Sawtooth: a = p[PHASE_W-1 -: DATA_W]; out = a − 2^(DATA_W-1) (MSB inversion).
- Triangle: b = p[PHASE_W-2 -: DATA_W]; f = MSB ? ~b : b; out = f − 2^(DATA_W-1).
- Mode and quadrant are delayed alongside the ROM read. The result for channel c is written to a shadow register.
- COMMIT: sample <= shadow, all channels simultaneously; new_sample_ready = 1 for exactly one cycle.
- Pulses ignored while in RUN set overrun. overrun clears only on reset.
- Reset, including mid-run: acc, shadow, sample = 0; new_sample_ready, busy, overrun = 0; state IDLE; in-flight work is discarded with no ready pulse.

## Timing
- Pulse accepted at edge E0. Channel c phase is registered at E(1+c), ROM data at E(2+c), shadow at E(3+c).
- Commit at E(N_CH+3): sample updates and new_sample_ready is high for the following cycle. The default latency is 5 cycles.
- busy is high from after E0 until E(N_CH+3), i.e. N_CH+3 cycles.
- A pulse coincident with the commit cycle is accepted. Maximum sustained rate is one set per N_CH+3 cycles, with no overrun.
- sample is stable between commits.

## Test plan
- Reset asserted while idle and mid-run (at E2) → all outputs 0. No ready pulse. The next pulse starts from acc=0.
- Ch0 sine, K=2^22, offset 0, four pulses → samples ROM[1023], 0, −ROM[1023], 0; each ready exactly 5 cycles after its pulse.
- Ch1 square, K=2^23 → −32767, then +32767, alternating. Ch0 with offset=2^23 reads opposite-sign sine quadrants.
- K=2^20: sawtooth → −28672 on first pulse; triangle → −24576. A mode change between pulses takes effect on the next set.
- A second pulse 2 cycles after the first → ignored, overrun=1, only one ready. A pulse in the commit cycle → accepted; ready period is 5.
- sync=1 with a pulse after several runs → both channels restart (acc=K). Phase wrap-around at 2^24 stays continuous.
